// File: rtl/keypad_scanner.sv
// Row-strobing scanner for a 4x4 active-low keypad with press/release debouncing.
// Emits one key_valid pulse per accepted press, carrying code = row*4 + column.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 4,
  parameter int unsigned DEBOUNCE_CNT = 3
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic [3:0] key_column,
  output logic [3:0] key_row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  DB_LAST  = 8'(DEBOUNCE_CNT);

  state_t      state_q, state_d;
  logic [1:0]  row_q, row_d;
  logic [15:0] div_q, div_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic        held_q, held_d;
  logic [3:0]  col_s1_q, col_s2_q;

  logic        sample;
  logic        press;
  logic [1:0]  col_idx;
  logic [3:0]  code_now;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      col_s1_q <= 4'b1111;
      col_s2_q <= 4'b1111;
      state_q  <= ST_SCAN;
      row_q    <= 2'd0;
      div_q    <= 16'd0;
      cnt_q    <= 8'd0;
      cand_q   <= 4'h0;
      code_q   <= 4'h0;
      valid_q  <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      col_s1_q <= key_column;
      col_s2_q <= col_s1_q;
      state_q  <= state_d;
      row_q    <= row_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      held_q   <= held_d;
    end
  end

  // Lowest closed column wins when several keys in the driven row are down.
  always_comb begin
    col_idx = 2'd0;
    if      (!col_s2_q[0]) col_idx = 2'd0;
    else if (!col_s2_q[1]) col_idx = 2'd1;
    else if (!col_s2_q[2]) col_idx = 2'd2;
    else if (!col_s2_q[3]) col_idx = 2'd3;
  end

  assign sample   = (div_q == DIV_LAST);
  assign press    = (col_s2_q != 4'b1111);
  assign code_now = {row_q, col_idx};

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    div_d   = sample ? 16'd0 : div_q + 16'd1;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    case (state_q)
      ST_SCAN: begin
        if (sample) begin
          if (!press) begin
            row_d = row_q + 2'd1;
          end else begin
            cand_d = code_now;
            cnt_d  = 8'd1;
            if (DEBOUNCE_CNT == 1) begin
              code_d  = code_now;
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = 8'd0;
              state_d = ST_HELD;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end
        end
      end
      ST_DEBOUNCE: begin
        if (sample) begin
          if (press && code_now == cand_q) begin
            if (cnt_q + 8'd1 == DB_LAST) begin
              code_d  = cand_q;
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = 8'd0;
              state_d = ST_HELD;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end else begin
            // A bounce throws away the candidate and rescans from the top row.
            state_d = ST_SCAN;
            row_d   = 2'd0;
            cnt_d   = 8'd0;
          end
        end
      end
      ST_HELD: begin
        if (sample) begin
          if (press) begin
            cnt_d = 8'd0;
          end else if (cnt_q + 8'd1 == DB_LAST) begin
            held_d  = 1'b0;
            cnt_d   = 8'd0;
            row_d   = 2'd0;
            state_d = ST_SCAN;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = ST_SCAN;
        row_d   = 2'd0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // key_valid is a bare one-cycle event: no ready, the consumer must take it when seen.
  assign key_row     = ~(4'b0001 << row_q);
  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_held    = held_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model closes keys on the driven row,
// and each scenario checks event timing, key codes and held behaviour.
module tb_keypad_scanner;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic [3:0]  key_column;
  logic [3:0]  key_row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [1:0]  dbg_state_o;

  logic [15:0] closed = 16'h0;
  logic        force_zero = 1'b0;
  int          cyc = 0;
  int          vcount = 0;
  int          vcyc = -1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk_in = ~clk_in;

  function automatic logic [3:0] kp(input logic [3:0] rows, input logic [15:0] cl);
    logic [3:0] col;
    col = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!rows[r] && cl[r*4+c]) col[c] = 1'b0;
    return col;
  endfunction

  assign key_column = force_zero ? 4'h0 : kp(key_row, closed);

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .key_column  (key_column),
    .key_row     (key_row),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_held    (key_held),
    .dbg_state_o (dbg_state_o)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
    if (key_valid) begin
      vcount++;
      vcyc = cyc;
    end
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  // Leaves the bench in cycle 0: first cycle with rst_n high, divider at 0.
  task automatic do_reset(input logic [15:0] keys);
    rst_n = 1'b0;
    closed = keys;
    repeat (3) tick();
    rst_n = 1'b1;
    cyc = 0;
    vcount = 0;
    vcyc = -1;
  endtask

  task automatic test_reset();
    force_zero = 1'b1;
    rst_n = 1'b0;
    closed = 16'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({key_row, key_code, key_valid, key_held} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: row=%b code=%h valid=%b held=%b, want 1110 0 0 0",
                 i, key_row, key_code, key_valid, key_held);
      end
    end
    force_zero = 1'b0;
    rst_n = 1'b1;
    cyc = 0;
    vcount = 0;
    for (int i = 0; i <= 16; i++) begin
      logic [3:0] exp_row;
      exp_row = ~(4'b0001 << ((i / 4) % 4));
      checks++;
      if (key_row !== exp_row) begin
        errors++;
        $display("FAIL scan_order cyc%0d: row=%b want %b", cyc, key_row, exp_row);
      end
      tick();
    end
    checks++;
    if (vcount !== 0) begin
      errors++;
      $display("FAIL scan_idle_events: got %0d want 0", vcount);
    end
  endtask

  task automatic test_single_press();
    do_reset(16'h0200);
    run_to(19);
    checks++;
    if (vcount !== 0 || key_held !== 1'b0) begin
      errors++;
      $display("FAIL single_early: events=%0d held=%b want 0 0", vcount, key_held);
    end
    tick();
    checks++;
    if ({key_valid, key_code, key_held} !== {1'b1, 4'd9, 1'b1}) begin
      errors++;
      $display("FAIL single_event c20: valid=%b code=%0d held=%b want 1 9 1",
               key_valid, key_code, key_held);
    end
    tick();
    checks++;
    if (key_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse_width c21: valid=%b want 0", key_valid);
    end
    run_to(30);
    closed = 16'h0;
    run_to(43);
    checks++;
    if (key_held !== 1'b1) begin
      errors++;
      $display("FAIL release_early c43: held=%b want 1", key_held);
    end
    tick();
    checks++;
    if ({key_held, key_row, key_code} !== {1'b0, 4'b1110, 4'd9}) begin
      errors++;
      $display("FAIL release c44: held=%b row=%b code=%0d want 0 1110 9",
               key_held, key_row, key_code);
    end
    run_to(48);
    checks++;
    if (key_row !== 4'b1101 || vcount !== 1) begin
      errors++;
      $display("FAIL rescan c48: row=%b events=%0d want 1101 1", key_row, vcount);
    end
  endtask

  task automatic test_bounce();
    do_reset(16'h0080);
    run_to(8);
    closed = 16'h0;
    run_to(11);
    closed = 16'h0080;
    run_to(27);
    checks++;
    if (vcount !== 0) begin
      errors++;
      $display("FAIL bounce_early c27: events=%0d want 0", vcount);
    end
    tick();
    checks++;
    if ({key_valid, key_code} !== {1'b1, 4'd7}) begin
      errors++;
      $display("FAIL bounce_event c28: valid=%b code=%0d want 1 7", key_valid, key_code);
    end
    run_to(60);
    checks++;
    if (vcount !== 1) begin
      errors++;
      $display("FAIL bounce_count: events=%0d want 1", vcount);
    end
  endtask

  task automatic test_hold_bounce();
    do_reset(16'h0200);
    run_to(20);
    for (int i = 0; i < 3; i++) begin
      run_to(24 + 12 * i);
      closed = 16'h0;
      run_to(32 + 12 * i);
      closed = 16'h0200;
    end
    run_to(80);
    checks++;
    if (vcount !== 1 || vcyc !== 20) begin
      errors++;
      $display("FAIL hold_bounce_events: events=%0d last_cyc=%0d want 1 20", vcount, vcyc);
    end
    checks++;
    if (key_held !== 1'b1 || key_code !== 4'd9) begin
      errors++;
      $display("FAIL hold_bounce_held: held=%b code=%0d want 1 9", key_held, key_code);
    end
  endtask

  task automatic test_simultaneous();
    do_reset(16'h0005);
    run_to(12);
    checks++;
    if ({key_valid, key_code} !== {1'b1, 4'd0} || vcount !== 1) begin
      errors++;
      $display("FAIL same_row c12: valid=%b code=%0d events=%0d want 1 0 1",
               key_valid, key_code, vcount);
    end
    do_reset(16'h1020);
    run_to(16);
    checks++;
    if ({key_valid, key_code} !== {1'b1, 4'd5} || vcount !== 1) begin
      errors++;
      $display("FAIL cross_row c16: valid=%b code=%0d events=%0d want 1 5 1",
               key_valid, key_code, vcount);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(16'h0200);
    run_to(14);
    rst_n = 1'b0;
    tick();
    checks++;
    if ({key_row, key_valid, key_held, dbg_state_o} !== {4'b1110, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_in_debounce: row=%b valid=%b held=%b st=%0d want 1110 0 0 0",
               key_row, key_valid, key_held, dbg_state_o);
    end
    do_reset(16'h0200);
    run_to(20);
    checks++;
    if ({key_valid, key_code, vcount} !== {1'b1, 4'd9, 32'd1}) begin
      errors++;
      $display("FAIL redetect_1 c20: valid=%b code=%0d events=%0d want 1 9 1",
               key_valid, key_code, vcount);
    end
    run_to(25);
    rst_n = 1'b0;
    tick();
    checks++;
    if ({key_row, key_code, key_valid, key_held, dbg_state_o} !==
        {4'b1110, 4'h0, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_in_held: row=%b code=%0d valid=%b held=%b st=%0d want 1110 0 0 0 0",
               key_row, key_code, key_valid, key_held, dbg_state_o);
    end
    do_reset(16'h0200);
    run_to(19);
    checks++;
    if (vcount !== 0) begin
      errors++;
      $display("FAIL redetect_2_early: events=%0d want 0", vcount);
    end
    tick();
    checks++;
    if ({key_valid, key_code, key_held} !== {1'b1, 4'd9, 1'b1}) begin
      errors++;
      $display("FAIL redetect_2 c20: valid=%b code=%0d held=%b want 1 9 1",
               key_valid, key_code, key_held);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_hold_bounce();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
